approx_rc_adder_pipe: RTL and testbench

Pipelined, parametrised successor of the 16-bit approximate ripple-carry adder. The low APPROX_BITS positions use the approximate cell (S = X, Cout = Y); the upper positions use exact full adders. Approximation can be switched off per transaction. A built-in exact reference path and error-statistics unit support the area/MSE characterisation flow. The block sits between a valid/ready stimulus source and a result sink.

---
 rtl/approx_adder_pkg.sv | 20 ++
 rtl/approx_rc_adder_pipe_seg.sv | 37 +++
 rtl/approx_rc_adder_pipe.sv | 164 ++++++++++++++++
 tb/tb_approx_rc_adder_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// Shared widths and mode encoding for the pipelined approximate adder.
// Imported by the segment adder and the pipeline top.
package approx_adder_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic int res_w(input int w);
    return w + 1;
  endfunction

  function automatic int err_w(input int w);
    return w + 2;
  endfunction

  function automatic int seg_w(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/approx_rc_adder_pipe_seg.sv
// Combinational segment of the ripple chain; each cell picks approximate
// or full-adder behaviour from its absolute bit position and the mode.
module approx_seg_adder
  import approx_adder_pkg::*;
#(
  parameter int SEG_W       = 8,
  parameter int SEG_LSB     = 0,
  parameter int APPROX_BITS = 10
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  logic [SEG_W:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      if (mode == MODE_APPROX && (SEG_LSB + i) < APPROX_BITS) begin
        sum[i]   = a[i];
        cy[i+1]  = b[i];
      end else begin
        sum[i]   = a[i] ^ b[i] ^ cy[i];
        cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
    end
  end

  assign cout = cy[SEG_W];

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// Pipelined approximate ripple-carry adder with exact reference path
// and handshake-gated error statistics.
module approx_rc_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 10,
  parameter int STAGES      = 2,
  parameter int ACC_W       = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic                      in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [res_w(WIDTH)-1:0]   out_sum,
  output logic [res_w(WIDTH)-1:0]   out_exact,
  output logic [err_w(WIDTH)-1:0]   out_err,
  input  logic                      stat_clr,
  output logic [31:0]               stat_cnt,
  output logic [ACC_W-1:0]          stat_sqerr,
  output logic [res_w(WIDTH)-1:0]   stat_maxabs
);

  localparam int RW  = res_w(WIDTH);
  localparam int EW  = err_w(WIDTH);
  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int SQW = 2 * RW;
  localparam int MW  = ((ACC_W > SQW) ? ACC_W : SQW) + 1;

  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [ACC_W-1:0] ACC_ONES = '1;

  // x carries {a upper, approx sum lower}, y carries {b upper, exact sum lower}
  logic [STAGES:0][WIDTH-1:0] x_q, y_q;
  logic [STAGES:1][WIDTH-1:0] x_n, y_n;
  logic [STAGES:0]            v_q;
  logic [STAGES-1:0]          m_q;
  logic [STAGES:1]            c_q, ec_q, c_n, ec_n;
  logic                       adv;

  assign in_ready = !out_valid | out_ready;
  assign adv      = in_ready;

  for (genvar s = 1; s <= STAGES; s++) begin : g_st
    localparam int LO = ((s - 1) * SEG < WIDTH) ? (s - 1) * SEG : WIDTH;
    localparam int HI = (LO + SEG < WIDTH) ? LO + SEG : WIDTH;
    localparam int SW = HI - LO;

    logic cin, ecin;

    if (s == 1) begin : g_c0
      assign cin  = 1'b0;
      assign ecin = 1'b0;
    end else begin : g_cn
      assign cin  = c_q[s-1];
      assign ecin = ec_q[s-1];
    end

    if (SW == 0) begin : g_pass
      assign x_n[s]  = x_q[s-1];
      assign y_n[s]  = y_q[s-1];
      assign c_n[s]  = cin;
      assign ec_n[s] = ecin;
    end else begin : g_seg
      localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << LO;

      logic [SW-1:0] sa, sb, ss;
      logic [SW:0]   ex;

      assign sa = x_q[s-1][LO +: SW];
      assign sb = y_q[s-1][LO +: SW];

      approx_seg_adder #(
        .SEG_W       (SW),
        .SEG_LSB     (LO),
        .APPROX_BITS (APPROX_BITS)
      ) u_seg (
        .a    (sa),
        .b    (sb),
        .cin  (cin),
        .mode (m_q[s-1]),
        .sum  (ss),
        .cout (c_n[s])
      );

      assign ex      = {1'b0, sa} + {1'b0, sb} + (SW+1)'(ecin);
      assign ec_n[s] = ex[SW];
      assign x_n[s]  = (x_q[s-1] & ~MASK) | (WIDTH'(ss) << LO);
      assign y_n[s]  = (y_q[s-1] & ~MASK) | (WIDTH'(ex[SW-1:0]) << LO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      v_q  <= '0;
      m_q  <= '0;
      c_q  <= '0;
      ec_q <= '0;
    end else if (adv) begin
      x_q[0] <= in_a;
      y_q[0] <= in_b;
      v_q[0] <= in_valid;
      m_q[0] <= in_mode;
      for (int s = 1; s <= STAGES; s++) begin
        x_q[s]  <= x_n[s];
        y_q[s]  <= y_n[s];
        c_q[s]  <= c_n[s];
        ec_q[s] <= ec_n[s];
        v_q[s]  <= v_q[s-1];
      end
      for (int s = 1; s < STAGES; s++) begin
        m_q[s] <= m_q[s-1];
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign out_sum   = {c_q[STAGES], x_q[STAGES]};
  assign out_exact = {ec_q[STAGES], y_q[STAGES]};
  assign out_err   = {1'b0, out_sum} - {1'b0, out_exact};

  logic              hs;
  logic [RW-1:0]     abs_err;
  logic [SQW-1:0]    sq;
  logic [31:0]       cnt_b;
  logic [ACC_W-1:0]  sq_b, sq_nx;
  logic [RW-1:0]     max_b;
  logic [MW-1:0]     tot;

  assign hs      = out_valid & out_ready;
  assign abs_err = out_err[EW-1] ? RW'(~out_err + 1'b1) : RW'(out_err);
  assign sq      = SQW'(abs_err) * SQW'(abs_err);

  // a clear in the same cycle as a handshake restarts from this result
  assign cnt_b = stat_clr ? '0 : stat_cnt;
  assign sq_b  = stat_clr ? '0 : stat_sqerr;
  assign max_b = stat_clr ? '0 : stat_maxabs;
  assign tot   = MW'(sq_b) + MW'(sq);
  assign sq_nx = (tot > MW'(ACC_ONES)) ? ACC_ONES : tot[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt    <= '0;
      stat_sqerr  <= '0;
      stat_maxabs <= '0;
    end else if (hs) begin
      stat_cnt    <= (&cnt_b) ? cnt_b : cnt_b + 32'd1;
      stat_sqerr  <= sq_nx;
      stat_maxabs <= (abs_err > max_b) ? abs_err : max_b;
    end else if (stat_clr) begin
      stat_cnt    <= '0;
      stat_sqerr  <= '0;
      stat_maxabs <= '0;
    end
  end

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Directed bench for approx_rc_adder_pipe at default parameters.
// Hand-computed vectors cover latency, modes, stalls, stats and reset.
module tb_approx_rc_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_sum;
  logic [16:0] out_exact;
  logic [17:0] out_err;
  logic        stat_clr;
  logic [31:0] stat_cnt;
  logic [47:0] stat_sqerr;
  logic [16:0] stat_maxabs;

  int n_cmp = 0;
  int n_bad = 0;

  approx_rc_adder_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_exact   (out_exact),
    .out_err     (out_err),
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt),
    .stat_sqerr  (stat_sqerr),
    .stat_maxabs (stat_maxabs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stream table: a, b, mode, expected sum, expected exact
  logic [15:0] ta [8] = '{16'h0003, 16'h03FF, 16'hFFFF, 16'h03FF,
                          16'h1234, 16'h1234, 16'h0400, 16'h8000};
  logic [15:0] tb [8] = '{16'h0001, 16'h0200, 16'hFFFF, 16'h0200,
                          16'h0001, 16'h0001, 16'h0400, 16'h8000};
  logic        tm [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [16:0] ts [8] = '{17'h00003, 17'h007FF, 17'h1FFFF, 17'h005FF,
                          17'h01235, 17'h01234, 17'h00800, 17'h10000};
  logic [16:0] tx [8] = '{17'h00004, 17'h005FF, 17'h1FFFE, 17'h005FF,
                          17'h01235, 17'h01235, 17'h00800, 17'h10000};

  // the three approximate vectors: err -1, +512, +1
  logic [15:0] aa [3] = '{16'h0003, 16'h03FF, 16'hFFFF};
  logic [15:0] ab [3] = '{16'h0001, 16'h0200, 16'hFFFF};
  logic [16:0] as [3] = '{17'h00003, 17'h007FF, 17'h1FFFF};
  logic [16:0] ax [3] = '{17'h00004, 17'h005FF, 17'h1FFFE};
  logic [17:0] ae [3] = '{18'h3FFFF, 18'h00200, 18'h00001};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    in_a = '0; in_b = '0; in_mode = 1'b0;
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_sum !== 17'h0 || out_exact !== 17'h0 || out_err !== 18'h0) begin
      n_bad++;
      $display("FAIL rst_data: got %h/%h/%h want 0/0/0", out_sum, out_exact, out_err);
    end
    n_cmp++;
    if (stat_cnt !== 32'h0 || stat_sqerr !== 48'h0 || stat_maxabs !== 17'h0) begin
      n_bad++;
      $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", stat_cnt, stat_sqerr, stat_maxabs);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_approx;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = aa[i]; in_b = ab[i]; in_mode = 1'b1;
      tick();
      in_valid = 1'b0;
      in_mode = 1'b0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL approx_early[%0d]: got %b want 0", i, out_valid);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++; $display("FAIL approx_latency[%0d]: got %b want 1", i, out_valid);
      end
      n_cmp++;
      if (out_sum !== as[i] || out_exact !== ax[i]) begin
        n_bad++;
        $display("FAIL approx_sum[%0d]: got %h/%h want %h/%h", i, out_sum, out_exact, as[i], ax[i]);
      end
      n_cmp++;
      if (out_err !== ae[i]) begin
        n_bad++; $display("FAIL approx_err[%0d]: got %h want %h", i, out_err, ae[i]);
      end
      tick();
    end
    n_cmp++;
    if (stat_cnt !== 32'd3 || stat_sqerr !== 48'd262146 || stat_maxabs !== 17'd512) begin
      n_bad++;
      $display("FAIL stats3: got %0d/%0d/%0d want 3/262146/512", stat_cnt, stat_sqerr, stat_maxabs);
    end
  endtask

  task automatic test_exact;
    logic [15:0] ea [2] = '{16'h03FF, 16'hFFFF};
    logic [15:0] eb [2] = '{16'h0200, 16'hFFFF};
    logic [16:0] es [2] = '{17'h005FF, 17'h1FFFE};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = ea[i]; in_b = eb[i]; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      in_mode = 1'b1;
      tick(); tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== es[i] || out_exact !== es[i]) begin
        n_bad++;
        $display("FAIL exact_sum[%0d]: got v=%b %h/%h want 1 %h", i, out_valid, out_sum, out_exact, es[i]);
      end
      n_cmp++;
      if (out_err !== 18'h0) begin
        n_bad++; $display("FAIL exact_err[%0d]: got %h want 0", i, out_err);
      end
      tick();
    end
    n_cmp++;
    if (stat_cnt !== 32'd5 || stat_sqerr !== 48'd262146 || stat_maxabs !== 17'd512) begin
      n_bad++;
      $display("FAIL stats5: got %0d/%0d/%0d want 5/262146/512", stat_cnt, stat_sqerr, stat_maxabs);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ba [4] = '{16'hFFFF, 16'hFFFF, 16'h03FF, 16'h03FF};
    logic [15:0] bb [4] = '{16'hFFFF, 16'hFFFF, 16'h0200, 16'h0200};
    logic        bm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [16:0] bs [4] = '{17'h1FFFF, 17'h1FFFE, 17'h007FF, 17'h005FF};
    logic [16:0] bx [4] = '{17'h1FFFE, 17'h1FFFE, 17'h005FF, 17'h005FF};
    int got = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_a = ba[c]; in_b = bb[c]; in_mode = bm[c];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready && got < 4) begin
        n_cmp++;
        if (out_sum !== bs[got] || out_exact !== bx[got]) begin
          n_bad++;
          $display("FAIL b2b[%0d]: got %h/%h want %h/%h", got, out_sum, out_exact, bs[got], bx[got]);
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 4) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 4", got);
    end
  endtask

  task automatic test_stall;
    int sent = 0;
    int got = 0;
    logic acc;
    logic stall;
    logic [16:0] hold_s;
    logic [16:0] hold_x;
    for (int c = 0; c < 40 && got < 8; c++) begin
      stall = (c >= 4 && c < 9);
      out_ready = !stall;
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_a = ta[sent]; in_b = tb[sent]; in_mode = tm[sent];
      end
      #1;
      if (stall) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL stall_ready[%0d]: got rdy=%b v=%b want 0 1", c, in_ready, out_valid);
        end
        if (c == 4) begin
          hold_s = out_sum; hold_x = out_exact;
        end else begin
          n_cmp++;
          if (out_sum !== hold_s || out_exact !== hold_x) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: got %h/%h want %h/%h", c, out_sum, out_exact, hold_s, hold_x);
          end
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (got >= 8 || out_sum !== ts[got] || out_exact !== tx[got]) begin
          n_bad++;
          $display("FAIL stream[%0d]: got %h/%h", got, out_sum, out_exact);
        end
        got++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got !== 8 || sent !== 8) begin
      n_bad++; $display("FAIL stream_count: got %0d/%0d want 8/8", got, sent);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_extra: got %b want 0", out_valid);
    end
  endtask

  task automatic test_clr;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = aa[i]; in_b = ab[i]; in_mode = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      if (i == 2) stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
    end
    n_cmp++;
    if (stat_cnt !== 32'd1 || stat_sqerr !== 48'd1 || stat_maxabs !== 17'd1) begin
      n_bad++;
      $display("FAIL clr_hs: got %0d/%0d/%0d want 1/1/1", stat_cnt, stat_sqerr, stat_maxabs);
    end
  endtask

  task automatic test_reset_flush;
    logic seen = 1'b0;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0001; in_mode = 1'b0;
    tick();
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_sum !== 17'h0) begin
      n_bad++; $display("FAIL flush_out: got v=%b %h want 0 0", out_valid, out_sum);
    end
    n_cmp++;
    if (stat_cnt !== 32'h0 || stat_sqerr !== 48'h0 || stat_maxabs !== 17'h0) begin
      n_bad++;
      $display("FAIL flush_stats: got %0d/%0d/%0d want 0/0/0", stat_cnt, stat_sqerr, stat_maxabs);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL flush_ghost: got 1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_approx();
    test_exact();
    test_back_to_back();
    test_stall();
    test_clr();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
